// File: rtl/ctrl_pipe_pkg.sv
// Shared decode constants, EX control bundle type and MDU FSM types for the
// ID/EX control pipeline.
package ctrl_pipe_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

   localparam logic [2:0] OPT_MEM = 3'b000;
   localparam logic [2:0] OPT_BR  = 3'b001;
   localparam logic [2:0] OPT_R   = 3'b010;
   localparam logic [2:0] OPT_I   = 3'b011;
   localparam logic [2:0] OPT_JMP = 3'b100;
   localparam logic [2:0] OPT_MDU = 3'b101;
   localparam logic [2:0] OPT_ILL = 3'b111;

   // Operand 1 and operand 2 codes are separate namespaces sharing 2 bits.
   localparam logic [1:0] OP1_REG      = 2'b00;
   localparam logic [1:0] OP1_PC       = 2'b01;
   localparam logic [1:0] OP1_NULL     = 2'b10;
   localparam logic [1:0] OP2_REG      = 2'b00;
   localparam logic [1:0] OP2_IMM      = 2'b01;
   localparam logic [1:0] OP2_PC_PLUS4 = 2'b10;

   localparam int MAX_LAT = 64;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_BUSY = 1'b1
   } mdu_state_e;

   typedef struct packed {
      logic [2:0] op_type;
      logic       is_jalr;
      logic [1:0] op1_type;
      logic [1:0] op2_type;
      logic       is_br;
      logic       mem_read_ena;
      logic       mem_write_ena;
      logic       reg_write_ena;
      logic       mem2reg;
      logic       is_mdu;
      logic       mdu_div;
      logic [4:0] rd;
   } ctrl_t;

   // One cycle of occupancy is the entry cycle and one is the final IDLE cycle.
   function automatic logic [CNT_W-1:0] lat_preload(input int lat);
      return (lat > 1) ? CNT_W'(lat - 2) : '0;
   endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// ID-side inputs and registered EX control bundle of the control pipeline.
interface ctrl_pipe_if;
   logic        id_valid;
   logic [31:0] id_inst;
   logic        flush_i;
   logic        stall_id;
   logic        ex_valid;
   logic [2:0]  ex_op_type;
   logic        ex_is_jalr;
   logic [1:0]  ex_operand1_type;
   logic [1:0]  ex_operand2_type;
   logic        ex_is_br;
   logic        ex_mem_read_ena;
   logic        ex_mem_write_ena;
   logic        ex_reg_write_ena;
   logic        ex_mem2reg;
   logic        ex_is_mdu;
   logic        ex_mdu_div;
   logic [4:0]  ex_rd;
   logic        mdu_busy;
   logic        ill_inst;

   modport master (
      output id_valid, id_inst, flush_i,
      input  stall_id, ex_valid, ex_op_type, ex_is_jalr, ex_operand1_type,
             ex_operand2_type, ex_is_br, ex_mem_read_ena, ex_mem_write_ena,
             ex_reg_write_ena, ex_mem2reg, ex_is_mdu, ex_mdu_div, ex_rd,
             mdu_busy, ill_inst
   );

   modport slave (
      input  id_valid, id_inst, flush_i,
      output stall_id, ex_valid, ex_op_type, ex_is_jalr, ex_operand1_type,
             ex_operand2_type, ex_is_br, ex_mem_read_ena, ex_mem_write_ena,
             ex_reg_write_ena, ex_mem2reg, ex_is_mdu, ex_mdu_div, ex_rd,
             mdu_busy, ill_inst
   );
endinterface

// File: rtl/ctrl_dec.sv
// Combinational ID-stage decoder: control bundle, register-use flags and
// illegal-opcode detection.
module ctrl_dec
   import ctrl_pipe_pkg::*;
#(
   parameter int EN_MEXT = 1
) (
   input  logic [31:0] inst,
   output ctrl_t       ctrl,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic        rs1_used,
   output logic        rs2_used,
   output logic        illegal
);
   logic [6:0] opc;
   logic [6:0] funct7;
   logic       unused_funct3;

   assign opc           = inst[6:0];
   assign funct7        = inst[31:25];
   assign rs1           = inst[19:15];
   assign rs2           = inst[24:20];
   assign unused_funct3 = ^inst[13:12];

   always_comb begin
      ctrl     = '0;
      ctrl.rd  = inst[11:7];
      illegal  = 1'b0;
      rs1_used = 1'b1;
      rs2_used = 1'b0;
      case (opc)
         OPC_LOAD: begin
            ctrl.op_type       = OPT_MEM;
            ctrl.op1_type      = OP1_REG;
            ctrl.op2_type      = OP2_IMM;
            ctrl.mem_read_ena  = 1'b1;
            ctrl.reg_write_ena = 1'b1;
            ctrl.mem2reg       = 1'b1;
         end
         OPC_STORE: begin
            ctrl.op_type       = OPT_MEM;
            ctrl.op1_type      = OP1_REG;
            ctrl.op2_type      = OP2_IMM;
            ctrl.mem_write_ena = 1'b1;
            rs2_used           = 1'b1;
         end
         OPC_LUI: begin
            ctrl.op_type       = OPT_MEM;
            ctrl.op1_type      = OP1_NULL;
            ctrl.op2_type      = OP2_IMM;
            ctrl.reg_write_ena = 1'b1;
            rs1_used           = 1'b0;
         end
         OPC_AUIPC: begin
            ctrl.op_type       = OPT_MEM;
            ctrl.op1_type      = OP1_PC;
            ctrl.op2_type      = OP2_IMM;
            ctrl.reg_write_ena = 1'b1;
            rs1_used           = 1'b0;
         end
         OPC_BRANCH: begin
            ctrl.op_type  = OPT_BR;
            ctrl.op1_type = OP1_REG;
            ctrl.op2_type = OP2_REG;
            ctrl.is_br    = 1'b1;
            rs2_used      = 1'b1;
         end
         OPC_R: begin
            ctrl.op1_type      = OP1_REG;
            ctrl.op2_type      = OP2_REG;
            ctrl.reg_write_ena = 1'b1;
            rs2_used           = 1'b1;
            if (funct7 == FUNCT7_MEXT) begin
               if (EN_MEXT != 0) begin
                  ctrl.op_type = OPT_MDU;
                  ctrl.is_mdu  = 1'b1;
                  ctrl.mdu_div = inst[14];
               end else begin
                  illegal = 1'b1;
               end
            end else begin
               ctrl.op_type = OPT_R;
            end
         end
         OPC_I: begin
            ctrl.op_type       = OPT_I;
            ctrl.op1_type      = OP1_REG;
            ctrl.op2_type      = OP2_IMM;
            ctrl.reg_write_ena = 1'b1;
         end
         OPC_JAL: begin
            ctrl.op_type       = OPT_JMP;
            ctrl.op1_type      = OP1_PC;
            ctrl.op2_type      = OP2_PC_PLUS4;
            ctrl.reg_write_ena = 1'b1;
            rs1_used           = 1'b0;
         end
         OPC_JALR: begin
            ctrl.op_type       = OPT_JMP;
            ctrl.op1_type      = OP1_PC;
            ctrl.op2_type      = OP2_PC_PLUS4;
            ctrl.is_jalr       = 1'b1;
            ctrl.reg_write_ena = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
      // Illegal instructions carry no side effects; only the trap code remains.
      if (illegal) begin
         ctrl         = '0;
         ctrl.op_type = OPT_ILL;
         ctrl.rd      = inst[11:7];
      end
   end
endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX control pipeline: load-use hazard bubble, multi-cycle MDU hold FSM
// and the registered EX control bundle.
module ctrl_pipe
   import ctrl_pipe_pkg::*;
#(
   parameter int EN_MEXT = 1,
   parameter int MUL_LAT = 2,
   parameter int DIV_LAT = 32
) (
   input logic        clk,
   input logic        rst_n,
   ctrl_pipe_if.slave bus
);
   if (MUL_LAT < 1 || MUL_LAT > MAX_LAT) begin : g_bad_mul_lat
      $error("MUL_LAT must be within 1..64");
   end
   if (DIV_LAT < 1 || DIV_LAT > MAX_LAT) begin : g_bad_div_lat
      $error("DIV_LAT must be within 1..64");
   end

   localparam logic [CNT_W-1:0] MUL_PRE  = lat_preload(MUL_LAT);
   localparam logic [CNT_W-1:0] DIV_PRE  = lat_preload(DIV_LAT);
   localparam logic             MUL_LONG = (MUL_LAT > 1);
   localparam logic             DIV_LONG = (DIV_LAT > 1);

   ctrl_t            dec_p0;
   logic [4:0]       rs1_p0, rs2_p0;
   logic             rs1_used_p0, rs2_used_p0, ill_p0;
   logic             hazard_p0, mdu_long_p0;
   logic [CNT_W-1:0] pre_p0;

   ctrl_t            ex_p1;
   logic             vld_p1, ill_p1, busy_p1;
   mdu_state_e       state_p1;
   logic [CNT_W-1:0] cnt_p1;

   ctrl_dec #(.EN_MEXT(EN_MEXT)) u_dec (
      .inst     (bus.id_inst),
      .ctrl     (dec_p0),
      .rs1      (rs1_p0),
      .rs2      (rs2_p0),
      .rs1_used (rs1_used_p0),
      .rs2_used (rs2_used_p0),
      .illegal  (ill_p0)
   );

   // ---- ID stage: hazard detection and MDU latency selection ----
   assign busy_p1     = (state_p1 == MDU_BUSY);
   assign hazard_p0   = vld_p1 & ex_p1.mem_read_ena & (ex_p1.rd != '0) & bus.id_valid &
                        ((rs1_used_p0 & (rs1_p0 == ex_p1.rd)) |
                         (rs2_used_p0 & (rs2_p0 == ex_p1.rd)));
   assign mdu_long_p0 = dec_p0.mdu_div ? DIV_LONG : MUL_LONG;
   assign pre_p0      = dec_p0.mdu_div ? DIV_PRE : MUL_PRE;

   // ---- ID/EX register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_p1    <= '0;
         vld_p1   <= 1'b0;
         ill_p1   <= 1'b0;
         state_p1 <= MDU_IDLE;
         cnt_p1   <= '0;
      end else if (bus.flush_i) begin
         ex_p1    <= '0;
         vld_p1   <= 1'b0;
         ill_p1   <= 1'b0;
         state_p1 <= MDU_IDLE;
         cnt_p1   <= '0;
      end else if (busy_p1) begin
         ill_p1 <= 1'b0;
         if (cnt_p1 == '0) begin
            state_p1 <= MDU_IDLE;
         end else begin
            cnt_p1 <= cnt_p1 - CNT_W'(1);
         end
      end else if (hazard_p0 || !bus.id_valid) begin
         ex_p1  <= '0;
         vld_p1 <= 1'b0;
         ill_p1 <= 1'b0;
      end else begin
         ex_p1  <= dec_p0;
         vld_p1 <= 1'b1;
         ill_p1 <= ill_p0;
         if (dec_p0.is_mdu && mdu_long_p0) begin
            state_p1 <= MDU_BUSY;
            cnt_p1   <= pre_p0;
         end
      end
   end

   assign bus.stall_id         = ~bus.flush_i & (busy_p1 | hazard_p0);
   assign bus.mdu_busy         = busy_p1;
   assign bus.ill_inst         = ill_p1;
   assign bus.ex_valid         = vld_p1;
   assign bus.ex_op_type       = ex_p1.op_type;
   assign bus.ex_is_jalr       = ex_p1.is_jalr;
   assign bus.ex_operand1_type = ex_p1.op1_type;
   assign bus.ex_operand2_type = ex_p1.op2_type;
   assign bus.ex_is_br         = ex_p1.is_br;
   assign bus.ex_mem_read_ena  = ex_p1.mem_read_ena;
   assign bus.ex_mem_write_ena = ex_p1.mem_write_ena;
   assign bus.ex_reg_write_ena = ex_p1.reg_write_ena;
   assign bus.ex_mem2reg       = ex_p1.mem2reg;
   assign bus.ex_is_mdu        = ex_p1.is_mdu;
   assign bus.ex_mdu_div       = ex_p1.mdu_div;
   assign bus.ex_rd            = ex_p1.rd;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: default build, EN_MEXT=0 build and a
// short-latency MDU build, all against hand-computed expectations.
module tb_ctrl_pipe;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   localparam logic [31:0] LW_X5   = 32'h00012283; // lw   x5,0(x2)
   localparam logic [31:0] ADD_X5  = 32'h00128333; // add  x6,x5,x1
   localparam logic [31:0] LW_X0   = 32'h00012003; // lw   x0,0(x2)
   localparam logic [31:0] ADD_X0  = 32'h00100333; // add  x6,x0,x1
   localparam logic [31:0] LUI_X9  = 32'h000284B7; // lui  x9, rs1 field = 5
   localparam logic [31:0] SW_X5   = 32'h00512023; // sw   x5,0(x2)
   localparam logic [31:0] MUL_X7  = 32'h022083B3; // mul  x7,x1,x2
   localparam logic [31:0] DIV_X8  = 32'h0220C433; // div  x8,x1,x2
   localparam logic [31:0] NOP     = 32'h00000013; // addi x0,x0,0
   localparam logic [31:0] ILL_OPC = 32'h0000007F;

   ctrl_pipe_if b0 ();
   ctrl_pipe_if b1 ();
   ctrl_pipe_if b2 ();

   ctrl_pipe u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
   ctrl_pipe #(.EN_MEXT(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
   ctrl_pipe #(.MUL_LAT(1), .DIV_LAT(3)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int mism;
      b0.id_valid = 1'b0; b0.id_inst = NOP; b0.flush_i = 1'b0;
      b1.id_valid = 1'b0; b1.id_inst = NOP; b1.flush_i = 1'b0;
      b2.id_valid = 1'b0; b2.id_inst = NOP; b2.flush_i = 1'b0;

      // Reset state
      #3;
      check_eq("rst_ex_valid", 32'(b0.ex_valid), 32'd0);
      check_eq("rst_stall", 32'(b0.stall_id), 32'd0);
      check_eq("rst_mdu_busy", 32'(b0.mdu_busy), 32'd0);
      check_eq("rst_ill", 32'(b0.ill_inst), 32'd0);
      check_eq("rst_op_type", 32'(b0.ex_op_type), 32'd0);
      tick(); tick();
      rst_n = 1'b1;

      // Load-use on rs1
      b0.id_valid = 1'b1; b0.id_inst = LW_X5; #1;
      check_eq("first_stall", 32'(b0.stall_id), 32'd0);
      tick();
      check_eq("lw_ex_valid", 32'(b0.ex_valid), 32'd1);
      check_eq("lw_mem_read", 32'(b0.ex_mem_read_ena), 32'd1);
      check_eq("lw_mem2reg", 32'(b0.ex_mem2reg), 32'd1);
      check_eq("lw_rd", 32'(b0.ex_rd), 32'd5);
      b0.id_inst = ADD_X5; #1;
      check_eq("lu_stall", 32'(b0.stall_id), 32'd1);
      tick();
      check_eq("lu_bubble_valid", 32'(b0.ex_valid), 32'd0);
      check_eq("lu_bubble_rw", 32'(b0.ex_reg_write_ena), 32'd0);
      check_eq("lu_stall_gone", 32'(b0.stall_id), 32'd0);
      tick();
      check_eq("lu_add_valid", 32'(b0.ex_valid), 32'd1);
      check_eq("lu_add_op", 32'(b0.ex_op_type), 32'd2);
      check_eq("lu_add_rd", 32'(b0.ex_rd), 32'd6);

      // rd = x0 load never stalls
      b0.id_inst = LW_X0; tick();
      b0.id_inst = ADD_X0; #1;
      check_eq("x0_no_stall", 32'(b0.stall_id), 32'd0);
      tick();
      check_eq("x0_add_op", 32'(b0.ex_op_type), 32'd2);

      // LUI does not use rs1 even when its bits match the load rd
      b0.id_inst = LW_X5; tick();
      b0.id_inst = LUI_X9; #1;
      check_eq("lui_no_stall", 32'(b0.stall_id), 32'd0);
      tick();
      check_eq("lui_rd", 32'(b0.ex_rd), 32'd9);
      check_eq("lui_op1", 32'(b0.ex_operand1_type), 32'd2);
      check_eq("lui_op2", 32'(b0.ex_operand2_type), 32'd1);

      // Store uses rs2
      b0.id_inst = LW_X5; tick();
      b0.id_inst = SW_X5; #1;
      check_eq("sw_stall", 32'(b0.stall_id), 32'd1);
      tick();
      check_eq("sw_bubble", 32'(b0.ex_valid), 32'd0);
      tick();
      check_eq("sw_mem_write", 32'(b0.ex_mem_write_ena), 32'd1);
      check_eq("sw_rw", 32'(b0.ex_reg_write_ena), 32'd0);

      // mul then div at default latencies
      b0.id_inst = MUL_X7; tick();
      check_eq("mul_op", 32'(b0.ex_op_type), 32'd5);
      check_eq("mul_is_mdu", 32'(b0.ex_is_mdu), 32'd1);
      check_eq("mul_div_bit", 32'(b0.ex_mdu_div), 32'd0);
      b0.id_inst = DIV_X8; #1;
      n = 0; mism = 0;
      while (b0.stall_id === 1'b1 && n < 100) begin
         if (b0.mdu_busy !== 1'b1) mism++;
         n++;
         tick();
      end
      check_eq("mul_stalls", 32'(n), 32'd1);
      check_eq("mul_busy_match", 32'(mism), 32'd0);
      check_eq("mul_last_busy", 32'(b0.mdu_busy), 32'd0);
      check_eq("mul_last_is_mdu", 32'(b0.ex_is_mdu), 32'd1);
      check_eq("mul_last_div", 32'(b0.ex_mdu_div), 32'd0);
      tick();
      check_eq("div_div_bit", 32'(b0.ex_mdu_div), 32'd1);
      n = 0; mism = 0;
      while (b0.stall_id === 1'b1 && n < 100) begin
         if (b0.mdu_busy !== 1'b1) mism++;
         n++;
         tick();
      end
      check_eq("div_stalls", 32'(n), 32'd31);
      check_eq("div_busy_match", 32'(mism), 32'd0);
      check_eq("div_last_div", 32'(b0.ex_mdu_div), 32'd1);
      b0.id_inst = NOP; tick();
      check_eq("after_div_op", 32'(b0.ex_op_type), 32'd3);

      // Flush at cycle 10 of a div
      b0.id_inst = DIV_X8; tick();
      b0.id_valid = 1'b0;
      repeat (9) tick();
      check_eq("fl_busy_c10", 32'(b0.mdu_busy), 32'd1);
      b0.flush_i = 1'b1; #1;
      check_eq("fl_stall_off", 32'(b0.stall_id), 32'd0);
      tick();
      b0.flush_i = 1'b0; #1;
      check_eq("fl_ex_valid", 32'(b0.ex_valid), 32'd0);
      check_eq("fl_mdu_busy", 32'(b0.mdu_busy), 32'd0);
      check_eq("fl_stall", 32'(b0.stall_id), 32'd0);

      // Illegal opcode
      b0.id_valid = 1'b1; b0.id_inst = ILL_OPC; tick();
      check_eq("ill_ex_valid", 32'(b0.ex_valid), 32'd1);
      check_eq("ill_op", 32'(b0.ex_op_type), 32'd7);
      check_eq("ill_pulse", 32'(b0.ill_inst), 32'd1);
      check_eq("ill_rw", 32'(b0.ex_reg_write_ena), 32'd0);
      b0.id_inst = NOP; tick();
      check_eq("ill_pulse_end", 32'(b0.ill_inst), 32'd0);
      b0.id_inst = ILL_OPC; b0.flush_i = 1'b1; tick();
      b0.flush_i = 1'b0;
      check_eq("ill_flush_pulse", 32'(b0.ill_inst), 32'd0);
      check_eq("ill_flush_valid", 32'(b0.ex_valid), 32'd0);

      // Reset during a div
      b0.id_inst = DIV_X8; tick();
      b0.id_valid = 1'b0;
      repeat (3) tick();
      check_eq("rb_busy_before", 32'(b0.mdu_busy), 32'd1);
      rst_n = 1'b0; #1;
      check_eq("rb_ex_valid", 32'(b0.ex_valid), 32'd0);
      check_eq("rb_mdu_busy", 32'(b0.mdu_busy), 32'd0);
      check_eq("rb_stall", 32'(b0.stall_id), 32'd0);
      check_eq("rb_is_mdu", 32'(b0.ex_is_mdu), 32'd0);
      check_eq("rb_op_type", 32'(b0.ex_op_type), 32'd0);
      check_eq("rb_rd", 32'(b0.ex_rd), 32'd0);
      tick();
      rst_n = 1'b1;
      b0.id_valid = 1'b1; b0.id_inst = ADD_X5; #1;
      check_eq("rb_next_stall", 32'(b0.stall_id), 32'd0);
      tick();
      check_eq("rb_next_valid", 32'(b0.ex_valid), 32'd1);
      check_eq("rb_next_op", 32'(b0.ex_op_type), 32'd2);
      b0.id_valid = 1'b0;

      // EN_MEXT=0: mul is illegal
      b1.id_valid = 1'b1; b1.id_inst = MUL_X7; tick();
      b1.id_valid = 1'b0;
      check_eq("nom_op", 32'(b1.ex_op_type), 32'd7);
      check_eq("nom_ill", 32'(b1.ill_inst), 32'd1);
      check_eq("nom_rw", 32'(b1.ex_reg_write_ena), 32'd0);
      check_eq("nom_valid", 32'(b1.ex_valid), 32'd1);
      check_eq("nom_busy", 32'(b1.mdu_busy), 32'd0);
      tick();
      check_eq("nom_ill_end", 32'(b1.ill_inst), 32'd0);
      check_eq("nom_bubble", 32'(b1.ex_valid), 32'd0);

      // MUL_LAT=1 (no stall), DIV_LAT=3 (two stalls)
      b2.id_valid = 1'b1; b2.id_inst = MUL_X7; tick();
      check_eq("l1_mul_op", 32'(b2.ex_op_type), 32'd5);
      check_eq("l1_mul_busy", 32'(b2.mdu_busy), 32'd0);
      b2.id_inst = DIV_X8; #1;
      check_eq("l1_mul_stall", 32'(b2.stall_id), 32'd0);
      tick();
      check_eq("l3_div_bit", 32'(b2.ex_mdu_div), 32'd1);
      n = 0;
      while (b2.stall_id === 1'b1 && n < 100) begin
         n++;
         tick();
      end
      check_eq("l3_div_stalls", 32'(n), 32'd2);
      check_eq("l3_div_held", 32'(b2.ex_mdu_div), 32'd1);
      b2.id_valid = 1'b0; tick();
      check_eq("l3_idle_bubble", 32'(b2.ex_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
